imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered immediate generator for the decode stage of the RV32I/RV64I pipeline. It accepts one 32-bit instruction per cycle through a valid/ready handshake and decodes all base immediate formats (I, S, B, U, J, plus R as zero). It sign-extends the immediate to XLEN and presents the result one cycle later through a 2-entry skid buffer. Pipeline flush support and optional shift-amount masking are included, which the earlier combinational I/S/B-only extender did not have.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- SHAMT_MASK, 1, when 1, OP-IMM shift immediates (funct3 001/101) are reduced to the zero-extended low $clog2(XLEN) bits.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered entries (branch mispredict/trap)
- in_valid  in  1  instruction presented
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  raw instruction
- out_valid  out  1  immediate available
- out_ready  in  1  downstream consumes this cycle
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 unknown
- out_instr  out  32  instruction passed through, aligned with out_imm

## Operation
- Opcode decode on in_instr[6:0]:
  - I-type: 0000011, 0010011, 1100111, 1110011. Immediate is sign-extended instr[31:20].
  - S-type: 0100011. Immediate is sign-extended {instr[31:25], instr[11:7]}.
  - B-type: 1100011. Immediate is sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: 0110111, 0010111. Immediate is {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J-type: 1101111. Immediate is sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: 0110011. Immediate is 0, fmt 0.
  - Any other opcode: immediate is 0, fmt 7. The entry is still transferred (illegal-instruction handling is downstream).
- Shift masking: applies only when SHAMT_MASK=1, opcode 0010011 and funct3 ∈ {001, 101}. Immediate is instr[20 +: $clog2(XLEN)], zero-extended.
- Decode is combinational on the input side. Results are registered into the main output register (M) or the skid register (K).
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Buffer rules:
  - in_ready = !K.valid, registered.
  - On an input transfer, the entry goes to M if M is empty or M is being transferred out this cycle with K empty. Otherwise it goes to K.
  - On an output transfer with K valid, K moves to M. In that same cycle in_ready is 0, so no input is accepted.
  - Order is strictly FIFO. Entries are never duplicated or dropped except by flush.
- Flush:
  - Next cycle, M.valid and K.valid are 0 and in_ready is 1.
  - An input offered in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as consumed.
- out_imm, out_fmt and out_instr hold stable while out_valid && !out_ready.

## Timing
- Reset: out_valid=0, in_ready=0 while rst is high and 1 in the first cycle after rst falls; out_imm=0, out_fmt=0, out_instr=0; K cleared.
- Latency: an input accepted in cycle N appears at the outputs in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- Backpressure:
  - With out_ready low, the block accepts at most 2 entries (M and K).
  - in_ready falls in the cycle after K fills.
  - in_ready rises in the cycle after the M transfer that drains K.
- Simultaneous flush and rst: rst wins; the result is identical.
- rst mid-transfer: all buffered entries are lost; no partial output.

## Test plan
- ADDI 0xFFF00093 with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
- SRAI 0x4030D093 → out_imm=0x00000003 with SHAMT_MASK=1; out_imm=0x00000403 with SHAMT_MASK=0.
- Back-to-back SW 0xFE20AE23, BEQ 0xFE000CE3, LUI 0x123452B7, JAL 0xFFDFF06F → outputs in order 0xFFFFFFFC/2, 0xFFFFFFF8/3, 0x12345000/4, 0xFFFFFFFC/5 on consecutive cycles.
- Hold out_ready=0 and stream 3 instructions → first 2 accepted, in_ready=0 from the cycle after the second acceptance. Raise out_ready → all emerge in order; the third is accepted only after K drains.
- Fill both entries, then pulse flush together with in_valid → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Opcode 0x7F and XLEN=64 LUI 0x800000B7 → fmt 7 with imm 0; then imm 0xFFFFFFFF80000000 with fmt 4.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: I/S/B/U/J/R immediates sign-extended to XLEN.
// Latency: one cycle from input acceptance to out_valid.
// Backpressure: 2-entry skid buffer (main M + skid K); in_ready drops while K holds an entry.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter bit SHAMT_MASK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [31:0]     instr;
    } entry_t;

    entry_t     dec_d;
    entry_t     m_q, k_q;
    logic       m_vld_q, m_vld_d;
    logic       k_vld_q, k_vld_d;
    logic       in_rdy_q, in_rdy_d;
    logic       in_xfer, out_xfer;
    logic       m_load_in, m_load_k, k_load;
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Combinational decode of the presented instruction into imm/fmt.
    always_comb begin
        dec_d.imm   = '0;
        dec_d.fmt   = FMT_X;
        dec_d.instr = in_instr;
        case (opcode)
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_d.fmt = FMT_I;
                dec_d.imm = XLEN'($signed(in_instr[31:20]));
            end
            7'b0010011: begin
                dec_d.fmt = FMT_I;
                // Shift-immediates carry funct7 in the upper bits; keep only shamt.
                if (SHAMT_MASK && (funct3 == 3'b001 || funct3 == 3'b101))
                    dec_d.imm = XLEN'(in_instr[20 +: SHW]);
                else
                    dec_d.imm = XLEN'($signed(in_instr[31:20]));
            end
            7'b0100011: begin
                dec_d.fmt = FMT_S;
                dec_d.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            7'b1100011: begin
                dec_d.fmt = FMT_B;
                dec_d.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                           in_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_d.fmt = FMT_U;
                dec_d.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_d.fmt = FMT_J;
                dec_d.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                           in_instr[30:21], 1'b0}));
            end
            7'b0110011: begin
                dec_d.fmt = FMT_R;
            end
            default: begin
                dec_d.fmt = FMT_X;
            end
        endcase
    end

    // rst gates in_ready directly so it reads 0 during reset and 1 right after.
    assign in_ready  = in_rdy_q & ~rst;
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign out_xfer  = m_vld_q & out_ready;
    assign out_valid = m_vld_q;
    assign out_imm   = m_q.imm;
    assign out_fmt   = m_q.fmt;
    assign out_instr = m_q.instr;

    // Buffer occupancy next-state: K refills M first, new entries go to M when it frees up.
    always_comb begin
        m_vld_d   = m_vld_q;
        k_vld_d   = k_vld_q;
        m_load_in = 1'b0;
        m_load_k  = 1'b0;
        k_load    = 1'b0;
        if (flush) begin
            m_vld_d = 1'b0;
            k_vld_d = 1'b0;
        end else if (k_vld_q) begin
            // in_ready is low here, so only the K->M move can happen.
            if (out_xfer) begin
                m_load_k = 1'b1;
                k_vld_d  = 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_vld_q || out_xfer) begin
                m_load_in = 1'b1;
                m_vld_d   = 1'b1;
            end else begin
                k_load  = 1'b1;
                k_vld_d = 1'b1;
            end
        end else if (out_xfer) begin
            m_vld_d = 1'b0;
        end
        in_rdy_d = ~k_vld_d;
    end

    // Valid flags and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q  <= 1'b0;
            k_vld_q  <= 1'b0;
            in_rdy_q <= 1'b1;
        end else begin
            m_vld_q  <= m_vld_d;
            k_vld_q  <= k_vld_d;
            in_rdy_q <= in_rdy_d;
        end
    end

    // Payload registers; M only changes on a load, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            k_q <= '0;
        end else begin
            if (m_load_in)
                m_q <= dec_d;
            else if (m_load_k)
                m_q <= k_q;
            if (k_load)
                k_q <= dec_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [31:0] imm_a, imm_b, ins_a, ins_b, ins_c;
    logic [63:0] imm_c;
    logic [2:0]  fmt_a, fmt_b, fmt_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];

    imm_gen_pipe #(.XLEN(32), .SHAMT_MASK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a),
        .out_fmt(fmt_a), .out_instr(ins_a));

    imm_gen_pipe #(.XLEN(32), .SHAMT_MASK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b),
        .out_fmt(fmt_b), .out_instr(ins_b));

    imm_gen_pipe #(.XLEN(64), .SHAMT_MASK(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_instr(in_instr), .out_valid(vld_c), .out_ready(out_ready), .out_imm(imm_c),
        .out_fmt(fmt_c), .out_instr(ins_c));

    // Reference immediate from the ISA field definitions using plain arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen, input bit mask);
        longint      v;
        logic [63:0] r;
        v = 0;
        case (ins[6:0])
            7'h03, 7'h67, 7'h73: v = longint'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
            7'h13: begin
                if (mask && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
                    v = longint'((ins >> 20) % xlen);
                else
                    v = longint'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
            end
            7'h23: v = longint'({ins[31:25], ins[11:7]}) - (ins[31] ? 64'd4096 : 64'd0);
            7'h63: v = 2 * longint'({ins[31], ins[7], ins[30:25], ins[11:8]})
                       - (ins[31] ? 64'd8192 : 64'd0);
            7'h37, 7'h17: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'd4294967296 : 64'd0);
            7'h6F: v = 2 * longint'({ins[31], ins[19:12], ins[20], ins[30:21]})
                       - (ins[31] ? 64'd2097152 : 64'd0);
            default: v = 0;
        endcase
        r = v;
        if (xlen == 32) r[63:32] = 32'h0;
        return r;
    endfunction

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 3'd1;
            7'h23:                      return 3'd2;
            7'h63:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h6F:                      return 3'd5;
            7'h33:                      return 3'd0;
            default:                    return 3'd7;
        endcase
    endfunction

    // Advance one clock and update the FIFO model of the buffered entries.
    task automatic tick();
        bit ix, ox;
        @(posedge clk);
        ix = in_valid && !rst && !flush && (mq.size() < 2);
        ox = (mq.size() > 0) && out_ready;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back(in_instr);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
        tick(); tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", vld_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_rdy_hi got %b exp 0", rdy_a); end
        rst = 1'b0; #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rst_rdy_lo got %b exp 1", rdy_a); end
        checks++; if (vld_a !== 1'b0 || vld_c !== 1'b0) begin errors++; $display("FAIL rst_vld_lo got %b%b exp 00", vld_a, vld_c); end
        checks++; if (imm_a !== 32'h0 || imm_c !== 64'h0) begin errors++; $display("FAIL rst_imm got %h %h exp 0", imm_a, imm_c); end
        checks++; if (fmt_a !== 3'd0 || ins_a !== 32'h0) begin errors++; $display("FAIL rst_fmt_instr got %0d %h exp 0 0", fmt_a, ins_a); end
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1; #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL addi_rdy got %b exp 1", rdy_a); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL addi_vld got %b exp 1", vld_a); end
        checks++; if (imm_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffff", imm_a); end
        checks++; if (fmt_a !== 3'd1) begin errors++; $display("FAIL addi_fmt got %0d exp 1", fmt_a); end
        checks++; if (ins_a !== 32'hFFF00093) begin errors++; $display("FAIL addi_instr got %h exp fff00093", ins_a); end
        checks++; if (imm_c !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm64 got %h exp all ones", imm_c); end
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL addi_drain got %b exp 0", vld_a); end
    endtask

    task automatic test_srai();
        in_valid = 1'b1; in_instr = 32'h4030D093; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        checks++; if (imm_a !== 32'h3) begin errors++; $display("FAIL srai_mask got %h exp 00000003", imm_a); end
        checks++; if (imm_b !== 32'h403) begin errors++; $display("FAIL srai_nomask got %h exp 00000403", imm_b); end
        checks++; if (imm_c !== 64'h3) begin errors++; $display("FAIL srai_mask64 got %h exp 3", imm_c); end
        checks++; if (fmt_a !== 3'd1) begin errors++; $display("FAIL srai_fmt got %0d exp 1", fmt_a); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog[4];
        logic [31:0] eimm[4];
        logic [2:0]  efmt[4];
        prog = '{32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'hFFDFF06F};
        eimm = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFC};
        efmt = '{3'd2, 3'd3, 3'd4, 3'd5};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin in_valid = 1'b1; in_instr = prog[k]; end
            else in_valid = 1'b0;
            #1;
            if (k < 4) begin
                checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b exp 1", k, rdy_a); end
            end
            if (k > 0) begin
                checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d] got %b exp 1", k - 1, vld_a); end
                checks++; if (imm_a !== eimm[k-1] || fmt_a !== efmt[k-1]) begin
                    errors++; $display("FAIL b2b_out[%0d] got %h/%0d exp %h/%0d", k - 1, imm_a, fmt_a, eimm[k-1], efmt[k-1]);
                end
                checks++; if (ins_a !== prog[k-1]) begin errors++; $display("FAIL b2b_instr[%0d] got %h exp %h", k - 1, ins_a, prog[k-1]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_rdy0 got %b exp 1", rdy_a); end
        tick();
        in_instr = 32'h00200093; #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_rdy1 got %b exp 1", rdy_a); end
        checks++; if (vld_a !== 1'b1 || imm_a !== 32'd1) begin errors++; $display("FAIL bp_first got %b/%h exp 1/1", vld_a, imm_a); end
        tick();
        in_instr = 32'h00300093;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_full_rdy[%0d] got %b exp 0", k, rdy_a); end
            checks++; if (imm_a !== 32'd1) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 1", k, imm_a); end
            tick();
        end
        out_ready = 1'b1; #1;
        checks++; if (rdy_a !== 1'b0 || imm_a !== 32'd1) begin errors++; $display("FAIL bp_drain0 got %b/%h exp 0/1", rdy_a, imm_a); end
        tick();
        checks++; if (rdy_a !== 1'b1 || vld_a !== 1'b1 || imm_a !== 32'd2) begin
            errors++; $display("FAIL bp_drain1 got rdy %b vld %b imm %h exp 1 1 2", rdy_a, vld_a, imm_a);
        end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (vld_a !== 1'b1 || imm_a !== 32'd3) begin errors++; $display("FAIL bp_third got %b/%h exp 1/3", vld_a, imm_a); end
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", vld_a); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; tick();
        in_instr = 32'h00200093; tick();
        flush = 1'b1; in_instr = 32'h00400093; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin errors++; $display("FAIL flush_full got vld %b rdy %b exp 0 1", vld_a, rdy_a); end
        tick(); tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL flush_full_after got %b exp 0", vld_a); end
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; tick();
        flush = 1'b1; in_instr = 32'h00400093; #1;
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL flush_one_rdy got %b exp 1", rdy_a); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
        checks++; if (vld_a !== 1'b0 || rdy_a !== 1'b1) begin errors++; $display("FAIL flush_one got vld %b rdy %b exp 0 1", vld_a, rdy_a); end
        tick();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL flush_discard got %b exp 0", vld_a); end
    endtask

    task automatic test_unknown_xlen64();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; tick();
        in_instr = 32'h800000B7; #1;
        checks++; if (fmt_a !== 3'd7 || imm_a !== 32'h0 || vld_a !== 1'b1) begin
            errors++; $display("FAIL unknown got fmt %0d imm %h vld %b exp 7 0 1", fmt_a, imm_a, vld_a);
        end
        checks++; if (fmt_c !== 3'd7 || imm_c !== 64'h0) begin errors++; $display("FAIL unknown64 got %0d/%h exp 7/0", fmt_c, imm_c); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (imm_c !== 64'hFFFFFFFF80000000 || fmt_c !== 3'd4) begin
            errors++; $display("FAIL lui64 got %h/%0d exp ffffffff80000000/4", imm_c, fmt_c);
        end
        checks++; if (imm_a !== 32'h80000000) begin errors++; $display("FAIL lui32 got %h exp 80000000", imm_a); end
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops[10];
        logic [31:0] r, ri, e;
        logic [6:0]  op;
        bit          erdy;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        for (int n = 0; n < 800; n++) begin
            r  = $urandom;
            ri = $urandom;
            rst       = (r[7:0] == 8'd0);
            flush     = (r[11:8] == 4'd0);
            in_valid  = r[12] | r[13];
            out_ready = r[14] | r[15];
            op = (r[19:16] < 4'd10) ? ops[r[19:16]] : ri[6:0];
            in_instr = {ri[31:7], op};
            #1;
            erdy = !rst && (mq.size() < 2);
            checks++; if (rdy_a !== erdy || rdy_c !== erdy) begin errors++; $display("FAIL rnd_rdy[%0d] got %b%b exp %b", n, rdy_a, rdy_c, erdy); end
            checks++; if (vld_a !== (mq.size() > 0) || vld_c !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_vld[%0d] got %b%b exp %0d", n, vld_a, vld_c, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                e = mq[0];
                checks++; if (ins_a !== e || ins_c !== e) begin errors++; $display("FAIL rnd_instr[%0d] got %h %h exp %h", n, ins_a, ins_c, e); end
                checks++; if (fmt_a !== ref_fmt(e) || fmt_c !== ref_fmt(e)) begin
                    errors++; $display("FAIL rnd_fmt[%0d] got %0d %0d exp %0d", n, fmt_a, fmt_c, ref_fmt(e));
                end
                checks++; if ({32'h0, imm_a} !== ref_imm(e, 32, 1'b1)) begin
                    errors++; $display("FAIL rnd_imm32[%0d] instr %h got %h exp %h", n, e, imm_a, ref_imm(e, 32, 1'b1));
                end
                checks++; if ({32'h0, imm_b} !== ref_imm(e, 32, 1'b0)) begin
                    errors++; $display("FAIL rnd_imm32nm[%0d] instr %h got %h exp %h", n, e, imm_b, ref_imm(e, 32, 1'b0));
                end
                checks++; if (imm_c !== ref_imm(e, 64, 1'b1)) begin
                    errors++; $display("FAIL rnd_imm64[%0d] instr %h got %h exp %h", n, e, imm_c, ref_imm(e, 64, 1'b1));
                end
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_srai();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_unknown_xlen64();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
